// File: rtl/store_align_pkg.sv
// rtl/store_align_pkg.sv - shared widths, store opcodes and FSM encoding for store_align
package store_align_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MASK_W   = 4;
  localparam int ALU_OP_W = 8;

  localparam logic [ALU_OP_W-1:0] ALU_OP_SB = 8'b1110_1000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SH = 8'b1110_1001;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SW = 8'b1110_1011;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

endpackage

// File: rtl/store_lane_gen.sv
// rtl/store_lane_gen.sv - combinational byte-lane shift, write mask and misalignment check
module store_lane_gen
  import store_align_pkg::*;
(
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [1:0]          offset,
  input  logic [DATA_W-1:0]   data,
  output logic [DATA_W-1:0]   wdata,
  output logic [MASK_W-1:0]   wmask,
  output logic                misalign,
  output logic                is_store
);

  always_comb begin
    wdata    = ZERO_WORD;
    wmask    = '0;
    misalign = 1'b0;
    is_store = 1'b1;
    case (alu_op)
      ALU_OP_SB: begin
        wdata = {24'b0, data[7:0]} << {offset, 3'b000};
        wmask = 4'b0001 << offset;
      end
      ALU_OP_SH: begin
        misalign = offset[0];
        wdata    = {16'b0, data[15:0]} << {offset, 3'b000};
        wmask    = 4'b0011 << offset;
      end
      ALU_OP_SW: begin
        misalign = (offset != 2'b00);
        wdata    = data;
        wmask    = 4'b1111;
      end
      default: is_store = 1'b0;
    endcase
  end

endmodule

// File: rtl/store_align.sv
// rtl/store_align.sv - aligns Execute stores and drives a req/ack write to Data_Mem with timeout
module store_align
  import store_align_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [ALU_OP_W-1:0] alu_op_i,
  input  logic [ADDR_W-1:0]   waddr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                wreq_o,
  input  logic                wack_i,
  output logic [ADDR_W-1:0]   waddr_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [MASK_W-1:0]   wmask_o,
  output logic                done_o,
  output logic                misalign_o,
  output logic                bus_err_o,
  output logic [ADDR_W-1:0]   badaddr_o
);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [ADDR_W-1:0]    req_addr;
  logic [DATA_W-1:0]    lane_wdata;
  logic [MASK_W-1:0]    lane_wmask;
  logic                 lane_misalign;
  logic                 lane_is_store;
  logic                 timeout_hit;

  store_lane_gen u_lane (
    .alu_op   (alu_op_i),
    .offset   (waddr_i[1:0]),
    .data     (wdata_i),
    .wdata    (lane_wdata),
    .wmask    (lane_wmask),
    .misalign (lane_misalign),
    .is_store (lane_is_store)
  );

  // An ack in the final allowed cycle wins over the timeout.
  assign timeout_hit = (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) && !wack_i;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (valid_i && lane_is_store)
          state_nxt = lane_misalign ? ST_FAULT : ST_SEND;
      end
      ST_SEND: begin
        if (wack_i || timeout_hit) state_nxt = ST_IDLE;
      end
      ST_FAULT: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_o    = (state == ST_IDLE);
    wreq_o     = (state == ST_SEND);
    misalign_o = (state == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      req_addr  <= '0;
      waddr_o   <= '0;
      wdata_o   <= ZERO_WORD;
      wmask_o   <= '0;
      done_o    <= 1'b0;
      bus_err_o <= 1'b0;
      badaddr_o <= '0;
    end else begin
      done_o    <= 1'b0;
      bus_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            if (!lane_is_store) begin
              done_o <= 1'b1;
            end else if (lane_misalign) begin
              badaddr_o <= waddr_i;
            end else begin
              waddr_o  <= {waddr_i[ADDR_W-1:2], 2'b00};
              wdata_o  <= lane_wdata;
              wmask_o  <= lane_wmask;
              req_addr <= waddr_i;
              cnt      <= '0;
            end
          end
        end
        ST_SEND: begin
          if (wack_i) begin
            done_o <= 1'b1;
            cnt    <= '0;
          end else if (timeout_hit) begin
            bus_err_o <= 1'b1;
            badaddr_o <= req_addr;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_store_align.sv
// tb/tb_store_align.sv - directed self-checking bench for store_align
module tb_store_align;
  import store_align_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                valid_i;
  logic                ready_o;
  logic [ALU_OP_W-1:0] alu_op_i;
  logic [ADDR_W-1:0]   waddr_i;
  logic [DATA_W-1:0]   wdata_i;
  logic                wreq_o;
  logic                wack_i;
  logic [ADDR_W-1:0]   waddr_o;
  logic [DATA_W-1:0]   wdata_o;
  logic [MASK_W-1:0]   wmask_o;
  logic                done_o;
  logic                misalign_o;
  logic                bus_err_o;
  logic [ADDR_W-1:0]   badaddr_o;

  int errors = 0;
  int checks = 0;

  store_align #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .alu_op_i(alu_op_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .wreq_o(wreq_o), .wack_i(wack_i), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .wmask_o(wmask_o), .done_o(done_o), .misalign_o(misalign_o),
    .bus_err_o(bus_err_o), .badaddr_o(badaddr_o)
  );

  always #5 clk = ~clk;

  // Presents one request for a single edge; returns at the negedge after acceptance.
  task automatic issue(input logic [ALU_OP_W-1:0] op, input logic [31:0] addr, input logic [31:0] data);
    valid_i  = 1'b1;
    alu_op_i = op;
    waddr_i  = addr;
    wdata_i  = data;
    @(negedge clk);
    valid_i  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; valid_i = 1'b0; wack_i = 1'b0;
    alu_op_i = '0; waddr_i = '0; wdata_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({ready_o, wreq_o, done_o, misalign_o, bus_err_o} !== 5'b10000) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=10000", {ready_o, wreq_o, done_o, misalign_o, bus_err_o});
    end
    checks++;
    if ({waddr_o, wdata_o, wmask_o, badaddr_o} !== '0) begin
      errors++; $display("FAIL reset_data waddr=%h wdata=%h wmask=%b bad=%h exp all zero", waddr_o, wdata_o, wmask_o, badaddr_o);
    end
  endtask

  task automatic test_sb;
    issue(ALU_OP_SB, 32'h8000_0003, 32'h1234_5678);
    checks++;
    if ({wreq_o, ready_o, waddr_o, wdata_o, wmask_o} !== {1'b1, 1'b0, 32'h8000_0000, 32'h7800_0000, 4'b1000}) begin
      errors++; $display("FAIL sb_lane wreq=%b ready=%b addr=%h data=%h mask=%b exp 1 0 80000000 78000000 1000", wreq_o, ready_o, waddr_o, wdata_o, wmask_o);
    end
    wack_i = 1'b1;
    @(negedge clk);
    wack_i = 1'b0;
    checks++;
    if ({done_o, wreq_o, ready_o} !== 3'b101) begin
      errors++; $display("FAIL sb_done done/wreq/ready got=%b exp=101", {done_o, wreq_o, ready_o});
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0) begin
      errors++; $display("FAIL sb_done_once got=%b exp=0", done_o);
    end
  endtask

  task automatic test_sh;
    issue(ALU_OP_SH, 32'h8000_0102, 32'hABCD_1234);
    checks++;
    if ({wreq_o, waddr_o, wdata_o, wmask_o} !== {1'b1, 32'h8000_0100, 32'h1234_0000, 4'b1100}) begin
      errors++; $display("FAIL sh_lane wreq=%b addr=%h data=%h mask=%b exp 1 80000100 12340000 1100", wreq_o, waddr_o, wdata_o, wmask_o);
    end
    wack_i = 1'b1;
    @(negedge clk);
    wack_i = 1'b0;
    checks++;
    if (done_o !== 1'b1) begin
      errors++; $display("FAIL sh_done got=%b exp=1", done_o);
    end
  endtask

  task automatic test_sw;
    issue(ALU_OP_SW, 32'h8000_0010, 32'hCAFE_F00D);
    @(negedge clk);
    checks++;
    if ({wreq_o, waddr_o, wdata_o, wmask_o} !== {1'b1, 32'h8000_0010, 32'hCAFE_F00D, 4'b1111}) begin
      errors++; $display("FAIL sw_hold wreq=%b addr=%h data=%h mask=%b exp 1 80000010 cafef00d 1111", wreq_o, waddr_o, wdata_o, wmask_o);
    end
    wack_i = 1'b1;
    @(negedge clk);
    wack_i = 1'b0;
    checks++;
    if ({done_o, ready_o} !== 2'b11) begin
      errors++; $display("FAIL sw_done got=%b exp=11", {done_o, ready_o});
    end
  endtask

  task automatic test_back_to_back;
    issue(ALU_OP_SB, 32'h8000_0001, 32'h0000_00A5);
    checks++;
    if ({wreq_o, wdata_o, wmask_o} !== {1'b1, 32'h0000_A500, 4'b0010}) begin
      errors++; $display("FAIL b2b_first wreq=%b data=%h mask=%b exp 1 0000a500 0010", wreq_o, wdata_o, wmask_o);
    end
    wack_i = 1'b1;
    @(negedge clk);
    wack_i = 1'b0;
    checks++;
    if ({wreq_o, ready_o, done_o} !== 3'b011) begin
      errors++; $display("FAIL b2b_gap wreq/ready/done got=%b exp=011", {wreq_o, ready_o, done_o});
    end
    issue(ALU_OP_SW, 32'h8000_0020, 32'hDEAD_BEEF);
    checks++;
    if ({wreq_o, waddr_o, wdata_o, wmask_o} !== {1'b1, 32'h8000_0020, 32'hDEAD_BEEF, 4'b1111}) begin
      errors++; $display("FAIL b2b_second wreq=%b addr=%h data=%h mask=%b exp 1 80000020 deadbeef 1111", wreq_o, waddr_o, wdata_o, wmask_o);
    end
    wack_i = 1'b1;
    @(negedge clk);
    wack_i = 1'b0;
    checks++;
    if (done_o !== 1'b1) begin
      errors++; $display("FAIL b2b_done got=%b exp=1", done_o);
    end
  endtask

  task automatic test_misalign_sw;
    issue(ALU_OP_SW, 32'h8000_0001, 32'h1111_1111);
    checks++;
    if ({misalign_o, wreq_o, ready_o, badaddr_o} !== {3'b100, 32'h8000_0001}) begin
      errors++; $display("FAIL misalign_sw_fault mis/wreq/ready=%b bad=%h exp 100 80000001", {misalign_o, wreq_o, ready_o}, badaddr_o);
    end
    @(negedge clk);
    checks++;
    if ({misalign_o, wreq_o, ready_o, badaddr_o} !== {3'b001, 32'h8000_0001}) begin
      errors++; $display("FAIL misalign_sw_after mis/wreq/ready=%b bad=%h exp 001 80000001", {misalign_o, wreq_o, ready_o}, badaddr_o);
    end
  endtask

  task automatic test_misalign_sh;
    issue(ALU_OP_SH, 32'h8000_0003, 32'h2222_2222);
    checks++;
    if ({misalign_o, wreq_o, badaddr_o} !== {2'b10, 32'h8000_0003}) begin
      errors++; $display("FAIL misalign_sh mis/wreq=%b bad=%h exp 10 80000003", {misalign_o, wreq_o}, badaddr_o);
    end
    @(negedge clk);
  endtask

  task automatic test_non_store;
    issue(8'h21, 32'h8000_0040, 32'h3333_3333);
    checks++;
    if ({done_o, wreq_o, ready_o, misalign_o} !== 4'b1010) begin
      errors++; $display("FAIL non_store done/wreq/ready/mis got=%b exp=1010", {done_o, wreq_o, ready_o, misalign_o});
    end
  endtask

  task automatic test_timeout;
    int n_req = 0, n_err = 0, n_done = 0;
    issue(ALU_OP_SW, 32'h8000_0080, 32'h4444_4444);
    for (int i = 0; i < 10; i++) begin
      if (wreq_o) n_req++;
      if (bus_err_o) n_err++;
      if (done_o) n_done++;
      @(negedge clk);
    end
    checks++;
    if ({n_req, n_err, n_done} !== {32'd4, 32'd1, 32'd0}) begin
      errors++; $display("FAIL timeout_counts req=%0d err=%0d done=%0d exp 4 1 0", n_req, n_err, n_done);
    end
    checks++;
    if ({badaddr_o, ready_o} !== {32'h8000_0080, 1'b1}) begin
      errors++; $display("FAIL timeout_badaddr bad=%h ready=%b exp 80000080 1", badaddr_o, ready_o);
    end
  endtask

  task automatic test_timeout_edge_ack;
    int n_req = 0, n_err = 0, n_done = 0;
    issue(ALU_OP_SW, 32'h8000_00C0, 32'h5555_5555);
    for (int i = 0; i < 10; i++) begin
      if (wreq_o) n_req++;
      if (bus_err_o) n_err++;
      if (done_o) n_done++;
      wack_i = (wreq_o && n_req == 4);
      @(negedge clk);
    end
    wack_i = 1'b0;
    checks++;
    if ({n_req, n_err, n_done} !== {32'd4, 32'd0, 32'd1}) begin
      errors++; $display("FAIL timeout_edge_ack req=%0d err=%0d done=%0d exp 4 0 1", n_req, n_err, n_done);
    end
    checks++;
    if (badaddr_o !== 32'h8000_0080) begin
      errors++; $display("FAIL timeout_edge_badaddr_held got=%h exp=80000080", badaddr_o);
    end
  endtask

  task automatic test_reset_in_send;
    issue(ALU_OP_SW, 32'h8000_0100, 32'h6666_6666);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({wreq_o, ready_o, done_o, misalign_o, bus_err_o, wmask_o} !== 9'b0_1_0_0_0_0000) begin
      errors++; $display("FAIL reset_in_send wreq/ready/done/mis/err/mask got=%b exp=010000000", {wreq_o, ready_o, done_o, misalign_o, bus_err_o, wmask_o});
    end
  endtask

  task automatic test_stray_ack;
    int n_done = 0;
    wack_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done_o) n_done++;
    end
    wack_i = 1'b0;
    checks++;
    if ({n_done, wreq_o, ready_o} !== {32'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL stray_ack done_count=%0d wreq=%b ready=%b exp 0 0 1", n_done, wreq_o, ready_o);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stray_ack();
    test_sb();
    test_sh();
    test_sw();
    test_back_to_back();
    test_misalign_sw();
    test_misalign_sh();
    test_non_store();
    test_timeout();
    test_timeout_edge_ack();
    test_reset_in_send();
    test_stray_ack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
